// File: rtl/raxm_pkg.sv
// raxm_pkg: shared constants and helpers for the wb_raxm_mac approximate MAC.
//   - Register byte offsets within the 256-byte Wishbone window
//   - CTRL / STATUS bit positions
//   - ke_clamp(): limits the truncation level to WIDTH-1
package raxm_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_OPA       = 8'h04;
  localparam logic [7:0] REG_OPB       = 8'h08;
  localparam logic [7:0] REG_STATUS    = 8'h0C;
  localparam logic [7:0] REG_RESULT_LO = 8'h10;
  localparam logic [7:0] REG_RESULT_HI = 8'h14;
  localparam logic [7:0] REG_ACC_LO    = 8'h18;
  localparam logic [7:0] REG_ACC_HI    = 8'h1C;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ACC_EN  = 1;
  localparam int CTRL_ACC_CLR = 2;
  localparam int CTRL_LA_SEL  = 3;
  localparam int CTRL_K_LSB   = 8;
  localparam int CTRL_IRQ_EN  = 16;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_OVF  = 2;
  localparam int STATUS_ERR  = 3;

  // Truncating every operand bit would always give zero; cap at WIDTH-1.
  function automatic logic [4:0] ke_clamp(input logic [4:0] k, input int width);
    if (int'(k) > width - 1) return 5'(width - 1);
    return k;
  endfunction

endpackage

// File: rtl/raxm_mul_pipe.sv
// raxm_mul_pipe: 3-stage truncated unsigned multiplier.
//   clk, rst      : clock, async active-high reset (valid bits only)
//   vld_in, a, b  : operand strobe and operands (WIDTH bits each)
//   ke            : clamped truncation level
//   vld_out       : product valid, three cycles after vld_in
//   product       : ((a>>ke)*(b>>ke))<<(2*ke), 2*WIDTH bits
//   occupied      : stage 0 or 1 holds an op (a new op cannot be accepted)
//   busy          : any stage holds an op
module raxm_mul_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         ke,
  output logic               vld_out,
  output logic [2*WIDTH-1:0] product,
  output logic               occupied,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] trunc_op(input logic [WIDTH-1:0] x,
                                                input logic [4:0] sh);
    return x >> sh;
  endfunction

  logic             vld_p0, vld_p1, vld_p2;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [4:0]       ke_p0, ke_p1;
  logic [PW-1:0]    prod_p1, prod_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= vld_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    // stage 0: drop the ke low bits of each operand
    a_p0  <= trunc_op(a, ke);
    b_p0  <= trunc_op(b, ke);
    ke_p0 <= ke;
    // stage 1: multiply the truncated operands
    prod_p1 <= PW'(a_p0) * PW'(b_p0);
    ke_p1   <= ke_p0;
    // stage 2: restore magnitude; cannot overflow since each factor < 2^(WIDTH-ke)
    prod_p2 <= prod_p1 << {ke_p1, 1'b0};
  end

  assign vld_out  = vld_p2;
  assign product  = prod_p2;
  assign occupied = vld_p0 | vld_p1;
  assign busy     = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: rtl/wb_raxm_mac.sv
// wb_raxm_mac: Wishbone-slave approximate multiply-accumulate engine.
//   wb_clk_i, wb_rst_i        : clock, async active-high reset
//   wbs_* (cyc/stb/we/sel/adr/dat_i, ack/dat_o) : classic Wishbone slave,
//                               256-byte window at BASE_ADDR, 2 cycles/access
//   la_data_in                : alternate operands [2W-1:0] and start edge [63]
//   la_data_out               : {STATUS[3:0], 28'b0, RESULT[31:0]}, one cycle late
//   irq_o                     : STATUS.done & CTRL.irq_en
module wb_raxm_mac #(
  parameter int          WIDTH     = 16,
  parameter int          ACC_W     = 2 * WIDTH + 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [63:0] la_data_in,
  output logic [63:0] la_data_out,
  output logic        irq_o
);
  import raxm_pkg::*;

  localparam int PW = 2 * WIDTH;

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    return r;
  endfunction

  logic             ack, la_prev;
  logic [31:0]      dat, rdata, ctrl_rd, ctrl_new;
  logic [63:0]      la_out, res64, acc64;
  logic             acc_en, la_sel, irq_en;
  logic [4:0]       k, ke;
  logic [WIDTH-1:0] opa, opb, op_a, op_b;
  logic [PW-1:0]    result, product;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             done, ovf, err;
  logic [3:0]       status;
  logic             hit, req, wr_hit, wr_ctrl;
  logic             start_req, start_go, acc_clr;
  logic             vld_out, occupied, busy;
  logic [7:0]       off;
  logic             unused_bits;

  assign hit     = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign off     = {wbs_adr_i[7:2], 2'b00};
  assign req     = wbs_cyc_i & wbs_stb_i & hit & ~ack;
  // Writes land while ack is high; Wishbone holds address/data through the ack.
  assign wr_hit  = ack & wbs_cyc_i & wbs_stb_i & wbs_we_i & hit;
  assign wr_ctrl = wr_hit && (off == REG_CTRL);

  assign ctrl_rd  = {15'd0, irq_en, 3'd0, k, 4'd0, la_sel, 1'b0, acc_en, 1'b0};
  assign ctrl_new = be_merge(ctrl_rd, wbs_dat_i, wbs_sel_i);
  assign acc_clr  = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_ACC_CLR];

  // The two start sources are mutually exclusive by la_sel.
  assign start_req = la_sel ? (la_data_in[63] & ~la_prev)
                            : (wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_START]);
  // The last stage frees up in its completion cycle, so only stages 0/1 block.
  assign start_go  = start_req & ~occupied;
  assign op_a      = la_sel ? la_data_in[WIDTH-1:0]    : opa;
  assign op_b      = la_sel ? la_data_in[PW-1:WIDTH]   : opb;
  assign ke        = ke_clamp(k, WIDTH);

  raxm_mul_pipe #(.WIDTH(WIDTH)) u_pipe (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .vld_in   (start_go),
    .a        (op_a),
    .b        (op_b),
    .ke       (ke),
    .vld_out  (vld_out),
    .product  (product),
    .occupied (occupied),
    .busy     (busy)
  );

  assign status  = {err, ovf, done, busy};
  assign res64   = 64'(result);
  assign acc64   = 64'(acc);
  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(product);

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:      rdata = ctrl_rd;
      REG_OPA:       rdata = 32'(opa);
      REG_OPB:       rdata = 32'(opb);
      REG_STATUS:    rdata = {28'd0, status};
      REG_RESULT_LO: rdata = res64[31:0];
      REG_RESULT_HI: rdata = res64[63:32];
      REG_ACC_LO:    rdata = acc64[31:0];
      REG_ACC_HI:    rdata = acc64[63:32];
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack     <= 1'b0;
      dat     <= '0;
      la_prev <= 1'b0;
      la_out  <= '0;
      acc_en  <= 1'b0;
      la_sel  <= 1'b0;
      k       <= '0;
      irq_en  <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      result  <= '0;
      acc     <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      ack     <= req;
      dat     <= (req && !wbs_we_i) ? rdata : '0;
      la_prev <= la_data_in[63];
      la_out  <= {status, 28'd0, res64[31:0]};

      if (wr_ctrl) begin
        acc_en <= ctrl_new[CTRL_ACC_EN];
        la_sel <= ctrl_new[CTRL_LA_SEL];
        k      <= ctrl_new[CTRL_K_LSB +: 5];
        irq_en <= ctrl_new[CTRL_IRQ_EN];
      end
      if (wr_hit && off == REG_OPA) opa <= WIDTH'(be_merge(32'(opa), wbs_dat_i, wbs_sel_i));
      if (wr_hit && off == REG_OPB) opb <= WIDTH'(be_merge(32'(opb), wbs_dat_i, wbs_sel_i));

      // W1C first so a same-cycle hardware set wins.
      if (wr_hit && off == REG_STATUS) begin
        done <= done & ~wbs_dat_i[STATUS_DONE];
        ovf  <= ovf  & ~wbs_dat_i[STATUS_OVF];
        err  <= err  & ~wbs_dat_i[STATUS_ERR];
      end
      if (start_req && occupied) err <= 1'b1;
      if (vld_out) begin
        result <= product;
        done   <= 1'b1;
      end

      // A clear in the completion cycle drops that product from the sum.
      if (acc_clr) acc <= '0;
      else if (vld_out && acc_en) begin
        acc <= acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

  assign wbs_ack_o   = ack;
  assign wbs_dat_o   = dat;
  assign la_data_out = la_out;
  assign irq_o       = done & irq_en;
  assign unused_bits = ^{wbs_adr_i[1:0], la_data_in};

endmodule

// File: tb/tb_wb_raxm_mac.sv
module tb_wb_raxm_mac;
  localparam int          WIDTH = 16;
  localparam int          ACC_W = 2 * WIDTH + 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk, rst;
  logic        cyc, stb, we, ack, irq;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic [63:0] la_in, la_out;

  wb_raxm_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_data_in(la_in), .la_data_out(la_out), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] sbq[$];

  typedef struct {
    logic [4:0]  k;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q);
    logic got = 1'b0;
    q = '0;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = BASE | 32'(off); wdat = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; q = rdat; break; end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_timeout: no ack at offset 0x%0h, required ack", off);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] q;
    bus(1'b1, off, d, s, q);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] q;
    bus(1'b0, off, 32'd0, 4'hF, q);
    check(name, q, exp);
  endtask

  task automatic wait_sb(input string name);
    int i = 0;
    while (sbq.size() != 0 && i < 60) begin @(posedge clk); i++; end
    #1;
    if (sbq.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: completion timeout, %0d pending, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  // Completion monitor: busy falling on la_data_out coincides with the new RESULT.
  logic prev_busy = 1'b0;
  int   run = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      run = 0;
    end else begin
      if (la_out[60]) run++;
      else if (prev_busy) begin
        check("busy_len", 64'(run), 64'd3);
        if (sbq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_completion: result 0x%0h, required none", la_out[31:0]);
        end else check("sb_result", la_out[31:0], sbq.pop_front());
        run = 0;
      end
      prev_busy = la_out[60];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; la_in = '0;
    vt[0] = '{5'd0,  16'h1234, 16'h5678, 32'h0626_0060};
    vt[1] = '{5'd4,  16'h1234, 16'h5678, 32'h0624_1500};
    vt[2] = '{5'd31, 16'h1234, 16'h5678, 32'h0000_0000};
    vt[3] = '{5'd0,  16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vt[4] = '{5'd1,  16'hFFFF, 16'hFFFF, 32'hFFFC_0004};
    vt[5] = '{5'd8,  16'hFF00, 16'h0100, 32'h00FF_0000};
    vt[6] = '{5'd15, 16'h8000, 16'h8000, 32'h4000_0000};

    repeat (3) @(posedge clk); #1;
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_irq", irq, 0);
    check("rst_la", la_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("rst_ctrl", 8'h00, 0);
    rd_chk("rst_status", 8'h0C, 0);
    rd_chk("rst_result", 8'h10, 0);

    // Table of single operations
    for (int i = 0; i < 7; i++) begin
      wr(8'h00, 32'(vt[i].k) << 8);
      wr(8'h04, 32'(vt[i].a));
      wr(8'h08, 32'(vt[i].b));
      sbq.push_back(vt[i].exp);
      wr(8'h00, (32'(vt[i].k) << 8) | 32'h1);
      wait_sb("vec");
      rd_chk("vec_result_lo", 8'h10, vt[i].exp);
      rd_chk("vec_result_hi", 8'h14, 0);
      rd_chk("vec_status", 8'h0C, 32'h2);
      wr(8'h0C, 32'h2);
    end

    // Byte enables on OPA
    wr(8'h04, 32'h1234);
    wr(8'h04, 32'hFFFF, 4'b0001);
    rd_chk("opa_sel", 8'h04, 32'h12FF);

    // Start while busy: second start two cycles later is rejected
    wr(8'h00, 0);
    wr(8'h04, 32'h1234);
    wr(8'h08, 32'h5678);
    sbq.push_back(32'h0626_0060);
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h1);
    wait_sb("busy_start");
    repeat (10) @(posedge clk); #1;
    rd_chk("busy_err", 8'h0C, 32'hA);
    wr(8'h0C, 32'hA);

    // OPA write during busy leaves in-flight op alone
    sbq.push_back(32'h0626_0060);
    wr(8'h00, 32'h1);
    wr(8'h04, 32'h0001);
    wait_sb("opa_busy");
    rd_chk("opa_busy_result", 8'h10, 32'h0626_0060);
    rd_chk("opa_busy_opa", 8'h04, 32'h0001);
    wr(8'h0C, 32'h2);

    // Accumulator wrap over 257 maximal products
    wr(8'h04, 32'hFFFF);
    wr(8'h08, 32'hFFFF);
    wr(8'h00, 32'h6);
    for (int i = 0; i < 257; i++) begin
      sbq.push_back(32'hFFFE_0001);
      wr(8'h00, 32'h3);
      wait_sb("acc_op");
    end
    rd_chk("acc_lo", 8'h18, 32'hFDFE_0101);
    rd_chk("acc_hi", 8'h1C, 32'h0);
    rd_chk("acc_status", 8'h0C, 32'h6);
    wr(8'h00, 32'h6);
    rd_chk("accclr_lo", 8'h18, 0);
    rd_chk("accclr_hi", 8'h1C, 0);
    rd_chk("accclr_ovf", 8'h0C, 32'h6);
    wr(8'h0C, 32'h6);
    rd_chk("w1c_status", 8'h0C, 0);

    // acc_clr landing in the completion cycle wins over accumulation
    sbq.push_back(32'hFFFE_0001);
    wr(8'h00, 32'h3);
    wait_sb("acc_one");
    rd_chk("acc_one_lo", 8'h18, 32'hFFFE_0001);
    sbq.push_back(32'hFFFE_0001);
    wr(8'h00, 32'h3);
    @(posedge clk); #1;
    wr(8'h00, 32'h6);
    wait_sb("acc_clr_done");
    rd_chk("acc_clr_done_lo", 8'h18, 0);
    rd_chk("acc_clr_done_res", 8'h10, 32'hFFFE_0001);
    wr(8'h0C, 32'h6);

    // LA start path with interrupt
    wr(8'h00, 32'h0001_0008);
    la_in = 64'h0000_0000_0003_0005;
    @(posedge clk); #1;
    sbq.push_back(32'h0000_000F);
    la_in[63] = 1'b1;
    wait_sb("la_op");
    check("la_out_result", la_out[31:0], 32'hF);
    check("la_out_done", la_out[61], 1);
    check("la_irq", irq, 1);
    wr(8'h0C, 32'h2);
    check("la_irq_clr", irq, 0);
    la_in = '0;
    wr(8'h00, 32'h0);
    la_in[63] = 1'b1;
    repeat (10) @(posedge clk); #1;
    la_in = '0;

    // Reset in the middle of an operation
    wr(8'h04, 32'h3);
    wr(8'h08, 32'h5);
    wr(8'h00, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_irq", irq, 0);
    check("midrst_dat", rdat, 0);
    check("midrst_la", la_out, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    rd_chk("midrst_result", 8'h10, 0);
    rd_chk("midrst_status", 8'h0C, 0);

    // Decode: outside the window never acks, unused offset reads zero
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; wdat = 32'h1; sel = 4'hF;
    repeat (6) begin @(posedge clk); #1; if (ack) got = 1'b1; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("miss_ack", got, 0);
    repeat (8) @(posedge clk); #1;
    rd_chk("unused_off", 8'h40, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
